// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared constants and types for the DES substitution stage:
//   SBOX_TABLE[8][64] : FIPS 46-3 S1..S8, indexed by row*16 + col
//   P_TABLE[32]       : FIPS 46-3 P permutation, bit 1 = MSB
//   des_half_t / des_exp_t / des_sbox_idx_t / des_state_t
//   des_n_groups()    : evaluation cycles per operation for a given width
//   des_cnt_w()       : group counter width (never zero)
//   des_perm()        : applies P to a 32-bit half block
// -----------------------------------------------------------------------------
package des_pkg;

   typedef logic [31:0] des_half_t;
   typedef logic [47:0] des_exp_t;
   typedef logic [2:0]  des_sbox_idx_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } des_state_t;

   function automatic int des_n_groups(input int spc);
      return 8 / spc;
   endfunction

   function automatic int des_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int SBOX_TABLE [8][64] = '{
      // S1
      '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
      // S2
      '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
      // S3
      '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
      // S4
      '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
      // S5
      '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
      // S6
      '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
      // S7
      '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
      // S8
      '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
   };

   localparam int P_TABLE [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25
   };

   // Output bit k (1 = MSB) takes input bit P_TABLE[k-1] (1 = MSB).
   function automatic des_half_t des_perm(input des_half_t v);
      des_half_t r;
      r = '0;
      for (int k = 0; k < 32; k++) begin
         r[31-k] = v[32-P_TABLE[k]];
      end
      return r;
   endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// -----------------------------------------------------------------------------
// des_sbox_lut
// Combinational lookup for one S-box lane. LANE fixes the lane position inside
// a group; the S-box actually used is i_grp*SPC + LANE, so with SPC=8 the
// select is constant and the lookup collapses to a single fixed table.
// Ports:
//   i_grp  : current group number
//   i_six  : 6-bit S-box input, b5 = MSB
//   o_nib  : 4-bit S-box output
// -----------------------------------------------------------------------------
module des_sbox_lut
   import des_pkg::*;
#(
   parameter int LANE = 0,
   parameter int SPC  = 8
) (
   input  des_sbox_idx_t i_grp,
   input  logic [5:0]    i_six,
   output logic [3:0]    o_nib
);

   des_sbox_idx_t w_sel;
   logic [5:0]    w_addr;

   assign w_sel  = des_sbox_idx_t'(int'(i_grp) * SPC + LANE);
   // row = {b5,b0}, col = b4..b1 -> flat index row*16 + col
   assign w_addr = {i_six[5], i_six[0], i_six[4:1]};
   assign o_nib  = 4'(SBOX_TABLE[w_sel][w_addr]);

endmodule

// File: rtl/des_sbox.sv
// -----------------------------------------------------------------------------
// des_sbox
// DES f-function substitution stage: x = data ^ key, then S1..S8 evaluated
// SBOX_PER_CYCLE at a time over N = 8/SBOX_PER_CYCLE cycles.
// Optional macro DES_SBOX_PERM_EN: result passes through P before the output
// register (same latency).
// Ports:
//   clk_in              : clock, rising edge
//   rst_in              : synchronous active-high reset
//   sbox_data_in [47:0] : expanded half block
//   sbox_key_in  [47:0] : round subkey
//   sbox_data_in_valid  : input qualifier (dropped when not ready)
//   sbox_ready_out      : can accept this cycle (combinational)
//   sbox_data_out[31:0] : result, held until next completion
//   sbox_data_out_valid : one-cycle completion pulse
// -----------------------------------------------------------------------------
module des_sbox
   import des_pkg::*;
#(
   parameter int SBOX_PER_CYCLE = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  des_exp_t    sbox_data_in,
   input  des_exp_t    sbox_key_in,
   input  logic        sbox_data_in_valid,
   output logic        sbox_ready_out,
   output des_half_t   sbox_data_out,
   output logic        sbox_data_out_valid
);

   localparam int N     = des_n_groups(SBOX_PER_CYCLE);
   localparam int CNT_W = des_cnt_w(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   des_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   des_exp_t         r_x;
   des_half_t        r_scratch;
   des_half_t        r_out;
   logic             r_out_valid;

   logic             w_last;
   logic             w_accept;
   des_half_t        w_merged;
   des_half_t        w_result;

   des_sbox_idx_t    w_idx [SBOX_PER_CYCLE];
   logic [5:0]       w_six [SBOX_PER_CYCLE];
   logic [3:0]       w_nib [SBOX_PER_CYCLE];

   // ---------------------------------------------------------------- control
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_last         = (r_state == S_RUN) && (r_cnt == CNT_LAST);
      sbox_ready_out = (r_state == S_IDLE) || w_last;
      w_accept       = sbox_data_in_valid && sbox_ready_out;
      if (w_accept) begin
         // also covers back-to-back: stay in RUN and restart the groups
         w_state_nxt = S_RUN;
         w_cnt_nxt   = '0;
      end else if (w_last) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else if (r_state == S_RUN) begin
         w_cnt_nxt   = r_cnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------- lanes
   // Lane l of group g handles S-box g*SBOX_PER_CYCLE + l (0-based); S1 sits
   // at the MSB end of both x and the result.
   for (genvar l = 0; l < SBOX_PER_CYCLE; l++) begin : g_lane
      assign w_idx[l] = des_sbox_idx_t'(int'(r_cnt) * SBOX_PER_CYCLE + l);
      assign w_six[l] = r_x[6*(7 - int'(w_idx[l])) +: 6];

      des_sbox_lut #(
         .LANE (l),
         .SPC  (SBOX_PER_CYCLE)
      ) u_lut (
         .i_grp (des_sbox_idx_t'(r_cnt)),
         .i_six (w_six[l]),
         .o_nib (w_nib[l])
      );
   end

   // Scratch with this group's nibbles dropped in; on the last group this is
   // the complete S1..S8 result.
   always_comb begin
      w_merged = r_scratch;
      for (int l = 0; l < SBOX_PER_CYCLE; l++) begin
         w_merged[4*(7 - int'(w_idx[l])) +: 4] = w_nib[l];
      end
   end

`ifdef DES_SBOX_PERM_EN
   assign w_result = des_perm(w_merged);
`else
   assign w_result = w_merged;
`endif

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_x         <= '0;
         r_scratch   <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= w_last;
         if (w_accept) begin
            r_x <= sbox_data_in ^ sbox_key_in;
         end
         if (r_state == S_RUN) begin
            r_scratch <= w_merged;
         end
         if (w_last) begin
            r_out <= w_result;
         end
      end
   end

   assign sbox_data_out       = r_out;
   assign sbox_data_out_valid = r_out_valid;

endmodule

// File: tb/tb_des_sbox.sv
// -----------------------------------------------------------------------------
// tb_des_sbox
// Four des_sbox instances (SBOX_PER_CYCLE = 1, 2, 4, 8) sharing data/key,
// each with its own valid and reset. Expected values come from a reference
// model working directly from the DES S-box / P tables kept in this file,
// plus the published known-answer vectors. Honors DES_SBOX_PERM_EN.
// -----------------------------------------------------------------------------
module tb_des_sbox;

   logic             clk = 1'b0;
   logic [3:0]       rst;
   logic [3:0]       vld;
   logic [47:0]      din;
   logic [47:0]      key;
   logic [3:0]       rdy;
   logic [3:0][31:0] dout;
   logic [3:0]       dvld;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 4; k++) begin : g_dut
      des_sbox #(
         .SBOX_PER_CYCLE (1 << k)
      ) u_dut (
         .clk_in              (clk),
         .rst_in              (rst[k]),
         .sbox_data_in        (din),
         .sbox_key_in         (key),
         .sbox_data_in_valid  (vld[k]),
         .sbox_ready_out      (rdy[k]),
         .sbox_data_out       (dout[k]),
         .sbox_data_out_valid (dvld[k])
      );
   end

   // S-box rows as 16 hex nibbles, column 0 leftmost.
   logic [63:0] SBR [8][4] = '{
      '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
      '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
      '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
      '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
      '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
      '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
      '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
      '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
   };

   int PT [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                   2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

   localparam logic [47:0] V2D = 48'h7A15557A1555;
   localparam logic [47:0] V2K = 48'h1B02EFFC7072;
`ifdef DES_SBOX_PERM_EN
   localparam logic [31:0] KAT2 = 32'h234AA9BB;
`else
   localparam logic [31:0] KAT2 = 32'h5C82B597;
`endif

   function automatic logic [31:0] ref_f(input logic [47:0] d, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] r;
      logic [31:0] p;
      logic [5:0]  six;
      logic [63:0] rowv;
      int          row, col;
      x = d ^ k;
      r = '0;
      for (int j = 0; j < 8; j++) begin
         six  = x[47-6*j -: 6];
         row  = 2 * int'(six[5]) + int'(six[0]);
         col  = int'(six[4:1]);
         rowv = SBR[j][row];
         r[31-4*j -: 4] = rowv[63-4*col -: 4];
      end
      p = r;
`ifdef DES_SBOX_PERM_EN
      for (int b = 0; b < 32; b++) p[31-b] = r[32-PT[b]];
`endif
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] rnd48();
      return {16'($urandom), 32'($urandom)};
   endfunction

   // Single isolated operation: ready/valid checked every cycle, exact latency.
   task automatic run_op(input int k, input logic [47:0] d, input logic [47:0] kk,
                         input logic [31:0] exp, input string tag);
      int n;
      n = 8 >> k;
      chk($sformatf("%s_spc%0d_rdy_idle", tag, 1 << k), rdy[k], 1);
      din = d; key = kk; vld[k] = 1'b1;
      @(negedge clk);
      vld[k] = 1'b0; din = rnd48(); key = rnd48();
      for (int c = 0; c < n; c++) begin
         chk($sformatf("%s_spc%0d_rdy_c%0d", tag, 1 << k, c), rdy[k], (c == n - 1));
         chk($sformatf("%s_spc%0d_vld_c%0d", tag, 1 << k, c), dvld[k], 0);
         @(negedge clk);
      end
      chk($sformatf("%s_spc%0d_vld", tag, 1 << k), dvld[k], 1);
      chk($sformatf("%s_spc%0d_data", tag, 1 << k), dout[k], exp);
      @(negedge clk);
      chk($sformatf("%s_spc%0d_pulse", tag, 1 << k), dvld[k], 0);
      chk($sformatf("%s_spc%0d_hold", tag, 1 << k), dout[k], exp);
      chk($sformatf("%s_spc%0d_rdy_end", tag, 1 << k), rdy[k], 1);
   endtask

   // Second op accepted on the completion edge of the first.
   task automatic b2b(input int k, input logic [47:0] d1, input logic [47:0] k1, input logic [31:0] e1,
                      input logic [47:0] d2, input logic [47:0] k2, input logic [31:0] e2,
                      input string tag);
      int n;
      n = 8 >> k;
      chk($sformatf("%s_spc%0d_rdy0", tag, 1 << k), rdy[k], 1);
      din = d1; key = k1; vld[k] = 1'b1;
      @(negedge clk);
      vld[k] = 1'b0;
      for (int c = 0; c < n - 1; c++) begin
         chk($sformatf("%s_spc%0d_busy_c%0d", tag, 1 << k, c), rdy[k], 0);
         @(negedge clk);
      end
      chk($sformatf("%s_spc%0d_rdy_last", tag, 1 << k), rdy[k], 1);
      din = d2; key = k2; vld[k] = 1'b1;
      @(negedge clk);
      vld[k] = 1'b0; din = rnd48();
      chk($sformatf("%s_spc%0d_vld1", tag, 1 << k), dvld[k], 1);
      chk($sformatf("%s_spc%0d_data1", tag, 1 << k), dout[k], e1);
      for (int c = 1; c < n; c++) begin
         @(negedge clk);
         chk($sformatf("%s_spc%0d_gap_c%0d", tag, 1 << k, c), dvld[k], 0);
         chk($sformatf("%s_spc%0d_rdy2_c%0d", tag, 1 << k, c), rdy[k], (c == n - 1));
      end
      @(negedge clk);
      chk($sformatf("%s_spc%0d_vld2", tag, 1 << k), dvld[k], 1);
      chk($sformatf("%s_spc%0d_data2", tag, 1 << k), dout[k], e2);
      @(negedge clk);
      chk($sformatf("%s_spc%0d_pulse2", tag, 1 << k), dvld[k], 0);
   endtask

   initial begin
      logic [47:0] d1, k1, d2, k2;
      rst = 4'hF; vld = '0; din = '0; key = '0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("reset_spc%0d_data", 1 << k), dout[k], 0);
         chk($sformatf("reset_spc%0d_vld", 1 << k), dvld[k], 0);
         chk($sformatf("reset_spc%0d_rdy", 1 << k), rdy[k], 1);
      end
      rst = '0;
      @(negedge clk);

      // Known-answer vectors
      for (int k = 0; k < 4; k++) begin
`ifdef DES_SBOX_PERM_EN
         run_op(k, 48'h0, 48'h0, ref_f(48'h0, 48'h0), "kat1");
`else
         run_op(k, 48'h0, 48'h0, 32'hEFA72C4D, "kat1");
`endif
         run_op(k, V2D, V2K, KAT2, "kat2");
      end

      // Back-to-back known answers
      for (int k = 0; k < 4; k++) begin
         b2b(k, 48'h0, 48'h0, ref_f(48'h0, 48'h0), V2D, V2K, KAT2, "b2b_kat");
      end

      // Input while busy is dropped (SBOX_PER_CYCLE=2, N=4)
      din = 48'h0; key = 48'h0; vld[1] = 1'b1;
      @(negedge clk);
      din = V2D; key = V2K;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("drop_rdy_c%0d", c), rdy[1], 0);
         chk($sformatf("drop_vld_c%0d", c), dvld[1], 0);
         @(negedge clk);
      end
      vld[1] = 1'b0;
      chk("drop_rdy_c3", rdy[1], 1);
      @(negedge clk);
      chk("drop_vld", dvld[1], 1);
      chk("drop_data", dout[1], ref_f(48'h0, 48'h0));
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("drop_idle_vld%0d", c), dvld[1], 0);
         chk($sformatf("drop_idle_rdy%0d", c), rdy[1], 1);
      end

      // Reset mid-operation (SBOX_PER_CYCLE=1, at cnt==2)
      din = rnd48(); key = rnd48(); vld[0] = 1'b1;
      @(negedge clk);
      vld[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk("rstmid_data", dout[0], 0);
      chk("rstmid_vld", dvld[0], 0);
      chk("rstmid_rdy", rdy[0], 1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("rstmid_novld%0d", c), dvld[0], 0);
      end
      run_op(0, 48'h0, 48'h0, ref_f(48'h0, 48'h0), "rstmid_after");

      // Randomized operations against the reference model
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 5; i++) begin
            d1 = rnd48(); k1 = rnd48();
            run_op(k, d1, k1, ref_f(d1, k1), "rnd");
         end
         for (int i = 0; i < 2; i++) begin
            d1 = rnd48(); k1 = rnd48(); d2 = rnd48(); k2 = rnd48();
            b2b(k, d1, k1, ref_f(d1, k1), d2, k2, ref_f(d2, k2), "rnd_b2b");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/des_sbox.md
Name: des_sbox

Overview:
- DES f-function substitution stage; sits directly downstream of the 32->48 expansion stage.
- Each accepted operation XORs the 48-bit expanded half-block with the 48-bit round subkey, then runs the eight DES S-boxes to produce 32 bits.
- S-boxes are evaluated in groups over one or more cycles, so area can be traded against latency.
- Output feeds the P permutation (optional in-block) and the round's L/R XOR.

Parameters:
SBOX_PER_CYCLE, 8, S-boxes evaluated per cycle; legal values 1, 2, 4, 8; N = 8/SBOX_PER_CYCLE evaluation cycles per operation.

Ports:
clk_in  input  1  clock; all logic on rising edge.
rst_in  input  1  reset; synchronous, active-high.
sbox_data_in  input  48  expanded half-block from the expansion stage.
sbox_key_in  input  48  round subkey.
sbox_data_in_valid  input  1  input qualifier.
sbox_ready_out  output  1  block can accept input this cycle.
sbox_data_out  output  32  substituted result (P-permuted if the macro is set).
sbox_data_out_valid  output  1  one-cycle pulse; sbox_data_out is valid.

Behaviour:
- Reset (rst_in=1 at a rising edge):
  - state IDLE; group counter 0; scratch register 0.
  - sbox_data_out 0; sbox_data_out_valid 0.
  - Any in-flight operation is discarded; no valid pulse is produced for it.
- States: IDLE, RUN.
- sbox_ready_out = (state==IDLE) || (state==RUN && cnt==N-1). It is combinational from state and counter.
- Accept: edge where sbox_data_in_valid && sbox_ready_out.
  - Latch x = sbox_data_in ^ sbox_key_in.
  - cnt <= 0; state <= RUN.
  - Input valid while not ready is ignored (dropped), not queued.
- RUN: at each edge, evaluate group g=cnt, i.e. S-boxes g*SBOX_PER_CYCLE+1 .. (g+1)*SBOX_PER_CYCLE, into scratch, then cnt++.
- Last group (cnt==N-1):
  - sbox_data_out <= complete result; sbox_data_out_valid <= 1 for exactly one cycle.
  - state <= IDLE, unless a new input is accepted on the same edge, in which case state stays RUN with cnt=0.
- Latency: accept at edge E0, valid visible after edge EN.
  - SBOX_PER_CYCLE=8: one cycle, full throughput (one result per cycle back-to-back).
  - SBOX_PER_CYCLE=1: eight cycles, one result per 8 cycles with back-to-back accept.
- sbox_data_out holds its last value until the next completion.
- S-box j (1..8):
  - input = x[47-6(j-1) -: 6] (S1 at MSB).
  - row = {b5,b0}; col = b4..b1.
  - 4-bit output placed at [31-4(j-1) -: 4].
  - Tables are the standard FIPS 46-3 S1..S8.
- No backpressure on output; downstream must consume the pulse.

Optional Feature:
DES_SBOX_PERM_EN
- Defined: the 32-bit result passes through the DES P permutation (FIPS 46-3 table, bit 1 = MSB) before registering into sbox_data_out. Latency is unchanged.
- Undefined: sbox_data_out is the raw S1..S8 concatenation.

Decomposition:
- des_pkg holds:
  - constant arrays SBOX_TABLE[8][64] of 4-bit values.
  - P_TABLE[32].
  - typedefs des_half_t (32b), des_exp_t (48b), des_sbox_idx_t.
  - a localparam helper for N.
- Sub-module des_sbox_lut: combinational, 6-bit in / 4-bit out, with a parameter selecting which S-box. Instantiated SBOX_PER_CYCLE times; the group counter muxes 6-bit slices in and demuxes nibbles out.

Test Plan:
1. Data=0x000000000000, key=0x000000000000, macro off -> sbox_data_out=0xEFA72C4D with one valid pulse, one cycle after accept (SBOX_PER_CYCLE=8), eight cycles after accept (SBOX_PER_CYCLE=1).
2. Data=0x7A15557A1555, key=0x1B02EFFC7072 -> 0x5C82B597 (macro off); 0x234AA9BB (DES_SBOX_PERM_EN defined).
3. Back-to-back accepts (vector 1 then vector 2 on consecutive ready cycles) for each SBOX_PER_CYCLE -> two valid pulses N cycles apart, correct values in order, no gaps beyond N.
4. With SBOX_PER_CYCLE=2, assert valid with vector 2 while ready=0 (mid-RUN) -> input dropped; only the original result appears; ready is high only in IDLE and at cnt==3.
5. rst_in=1 for one edge at cnt==2 of an operation with SBOX_PER_CYCLE=1 -> no valid pulse; sbox_data_out=0; ready=1 on the next cycle; a subsequent vector 1 yields 0xEFA72C4D normally.
